// File: rtl/key_press_classifier.sv
// Push-button front end: two-flop synchroniser, debounce FSM and a gesture
// classifier that turns debounced presses into short / double / long events.
module key_press_classifier #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int DOUBLE_CYC   = 15_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_state,
  output logic key_flag,
  output logic short_flag,
  output logic double_flag,
  output logic long_flag
);

  // debounce:   UP     | released and stable
  //             F_DOWN | ks low, qualifying a press
  //             DOWN   | pressed and stable
  //             F_UP   | ks high, qualifying a release
  // classifier: C_IDLE  | no gesture in progress
  //             C_HELD  | first press held, timing towards long
  //             C_LONG  | long already reported, waiting for release
  //             C_GAP   | released, timing the double-press window
  //             C_HELD2 | second press of a double, waiting for release
  localparam logic [1:0] UP     = 2'd0;
  localparam logic [1:0] F_DOWN = 2'd1;
  localparam logic [1:0] DOWN   = 2'd2;
  localparam logic [1:0] F_UP   = 2'd3;

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_HELD  = 3'd1;
  localparam logic [2:0] C_LONG  = 3'd2;
  localparam logic [2:0] C_GAP   = 3'd3;
  localparam logic [2:0] C_HELD2 = 3'd4;

  localparam int DW       = $clog2(DEBOUNCE_CYC);
  localparam int HOLD_MAX = (LONG_CYC > DOUBLE_CYC) ? LONG_CYC : DOUBLE_CYC;
  localparam int CW       = $clog2(HOLD_MAX);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(DOUBLE_CYC - 1);

  logic          s1;
  logic          ks;
  logic [1:0]    db_st, db_nxt;
  logic [DW-1:0] db_cnt, db_cnt_nxt;
  logic          press_acc, release_acc;

  logic [2:0]    cl_st, cl_nxt;
  logic [CW-1:0] cl_cnt, cl_cnt_nxt;
  logic          short_set, double_set, long_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      ks <= 1'b1;
    end else begin
      s1 <= key_in;
      ks <= s1;
    end
  end

  always_comb begin
    db_nxt      = db_st;
    db_cnt_nxt  = db_cnt;
    press_acc   = 1'b0;
    release_acc = 1'b0;
    case (db_st)
      UP: begin
        if (!ks) begin
          db_nxt     = F_DOWN;
          db_cnt_nxt = '0;
        end
      end
      F_DOWN: begin
        if (ks) begin
          db_nxt     = UP;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          db_nxt     = DOWN;
          db_cnt_nxt = '0;
          press_acc  = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + DW'(1);
        end
      end
      DOWN: begin
        if (ks) begin
          db_nxt     = F_UP;
          db_cnt_nxt = '0;
        end
      end
      F_UP: begin
        if (!ks) begin
          db_nxt     = DOWN;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          db_nxt      = UP;
          db_cnt_nxt  = '0;
          release_acc = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + DW'(1);
        end
      end
      default: begin
        db_nxt     = UP;
        db_cnt_nxt = '0;
      end
    endcase
  end

  // The classifier consumes the acceptance strobes directly so that
  // double_flag lands in the same cycle as the key_flag that caused it.
  always_comb begin
    cl_nxt     = cl_st;
    cl_cnt_nxt = cl_cnt;
    short_set  = 1'b0;
    double_set = 1'b0;
    long_set   = 1'b0;
    case (cl_st)
      C_IDLE: begin
        cl_cnt_nxt = '0;
        if (press_acc) cl_nxt = C_HELD;
      end
      C_HELD: begin
        if (cl_cnt == LONG_LAST) begin
          long_set   = 1'b1;
          cl_nxt     = release_acc ? C_IDLE : C_LONG;
          cl_cnt_nxt = '0;
        end else if (release_acc) begin
          cl_nxt     = C_GAP;
          cl_cnt_nxt = '0;
        end else begin
          cl_cnt_nxt = cl_cnt + CW'(1);
        end
      end
      C_LONG: begin
        cl_cnt_nxt = '0;
        if (release_acc) cl_nxt = C_IDLE;
      end
      C_GAP: begin
        if (press_acc) begin
          double_set = 1'b1;
          cl_nxt     = C_HELD2;
          cl_cnt_nxt = '0;
        end else if (cl_cnt == GAP_LAST) begin
          short_set  = 1'b1;
          cl_nxt     = C_IDLE;
          cl_cnt_nxt = '0;
        end else begin
          cl_cnt_nxt = cl_cnt + CW'(1);
        end
      end
      C_HELD2: begin
        cl_cnt_nxt = '0;
        if (release_acc) cl_nxt = C_IDLE;
      end
      default: begin
        cl_nxt     = C_IDLE;
        cl_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_st       <= UP;
      db_cnt      <= '0;
      cl_st       <= C_IDLE;
      cl_cnt      <= '0;
      key_state   <= 1'b1;
      key_flag    <= 1'b0;
      short_flag  <= 1'b0;
      double_flag <= 1'b0;
      long_flag   <= 1'b0;
    end else begin
      db_st       <= db_nxt;
      db_cnt      <= db_cnt_nxt;
      cl_st       <= cl_nxt;
      cl_cnt      <= cl_cnt_nxt;
      if (press_acc)
        key_state <= 1'b0;
      else if (release_acc)
        key_state <= 1'b1;
      key_flag    <= press_acc;
      short_flag  <= short_set;
      double_flag <= double_set;
      long_flag   <= long_set;
    end
  end

endmodule

// File: tb/tb_key_press_classifier.sv
// Scoreboard bench: stimulus pushes expected flag events (kind, cycle),
// a negedge monitor pops and compares whenever any flag is high.
module tb_key_press_classifier;

  localparam int DEB = 8;
  localparam int LNG = 100;
  localparam int DBL = 40;

  localparam int K_KEY    = 0;
  localparam int K_SHORT  = 1;
  localparam int K_DOUBLE = 2;
  localparam int K_LONG   = 3;
  localparam int K_NONE   = -1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_in = 1'b1;
  logic key_state, key_flag, short_flag, double_flag, long_flag;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;

  key_press_classifier #(
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC    (LNG),
    .DOUBLE_CYC  (DBL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_flag   (key_flag),
    .short_flag (short_flag),
    .double_flag(double_flag),
    .long_flag  (long_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int req);
    n_checks++;
    if (got == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, got, req, cyc);
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Called at a negedge. Holds key low for len sampling edges; the press
  // is expected 10 edges after the first low edge, plus one optional extra event.
  task automatic press(input int len, input int extra_kind, input int extra_off);
    int n;
    key_in = 1'b0;
    n = cyc + 1;
    push(K_KEY, n + DEB + 2);
    if (extra_kind != K_NONE) push(extra_kind, n + extra_off);
    repeat (len) @(negedge clk);
    key_in = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      logic [3:0] fl;
      fl = {long_flag, double_flag, short_flag, key_flag};
      for (int k = 0; k < 4; k++) begin
        if (fl[k]) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_flag: kind %0d at cyc %0d, required none", k, cyc);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.kind == k && e.cyc == cyc) n_pass++;
            else $display("FAIL flag_event: got kind %0d cyc %0d, required kind %0d cyc %0d",
                          k, cyc, e.kind, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({key_state, key_flag, short_flag, double_flag, long_flag}), 5'b10000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // bounce rejection: 7-cycle lows never qualify
    repeat (5) begin
      key_in = 1'b0;
      repeat (DEB - 1) @(negedge clk);
      key_in = 1'b1;
      repeat (12) @(negedge clk);
      check("bounce_key_state", int'(key_state), 1);
    end

    // clean short press
    press(30, K_SHORT, 30 + DEB + 2 + DBL);
    check("short_held_state", int'(key_state), 0);
    repeat (20) @(negedge clk);
    check("short_released_state", int'(key_state), 1);
    repeat (60) @(negedge clk);

    // double press, 15-cycle gap
    press(20, K_NONE, 0);
    repeat (15) @(negedge clk);
    press(20, K_DOUBLE, DEB + 2);
    repeat (80) @(negedge clk);

    // long press
    press(150, K_LONG, DEB + 2 + LNG);
    check("long_held_state", int'(key_state), 0);
    repeat (80) @(negedge clk);
    check("long_released_state", int'(key_state), 1);

    // gap boundary: second press accepted as the gap counter hits 39
    press(20, K_NONE, 0);
    repeat (DBL) @(negedge clk);
    press(20, K_DOUBLE, DEB + 2);
    repeat (80) @(negedge clk);

    // reset mid-hold
    begin
      int n;
      key_in = 1'b0;
      n = cyc + 1;
      push(K_KEY, n + DEB + 2);
      repeat (DEB + 2 + 51) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_outputs", int'({key_state, key_flag, short_flag, double_flag, long_flag}), 5'b10000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      n = cyc + 1;
      push(K_KEY, n + DEB + 2);
      push(K_LONG, n + DEB + 2 + LNG);
      repeat (130) @(negedge clk);
      key_in = 1'b1;
      repeat (80) @(negedge clk);
      check("post_reset_state", int'(key_state), 1);
    end

    check("pending_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_press_classifier.md
# key_press_classifier

Upstream input stage for the key-driven LED state machines. Synchronises and debounces one raw active-low push-button. It emits a single-cycle `key_flag` on every debounced press, which consumer FSMs use as their step event. It also classifies each gesture as short, double or long press, so later FSMs can act on richer events without their own timers.

## Interface
- `DEBOUNCE_CYC`, 1_000_000: consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); must be ≥ 2.
- `LONG_CYC`, 50_000_000: debounced-down cycles after which a press counts as long (1 s); must be > `DEBOUNCE_CYC`.
- `DOUBLE_CYC`, 15_000_000: maximum debounced-up gap between two presses for a double press (300 ms); must be ≥ 2.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_in` in 1: raw button level, 0 = pressed; asynchronous to `clk`, may bounce.
- `key_state` out 1: debounced level, 0 = pressed.
- `key_flag` out 1: one-cycle pulse on each accepted press.
- `short_flag` out 1: one-cycle pulse, single short press completed.
- `double_flag` out 1: one-cycle pulse, second press of a double press.
- `long_flag` out 1: one-cycle pulse, press held `LONG_CYC` cycles.

## Operation
- **Synchroniser:** two flops, both reset to 1. Everything downstream uses the second-stage output `ks`.
- **Debounce FSM:**
  - States: `UP`, `F_DOWN`, `DOWN`, `F_UP`. Reset state is `UP`.
  - Debounce counter is `$clog2(DEBOUNCE_CYC)` bits wide and is cleared on every state change.
  - `UP`: when `ks`=0, go to `F_DOWN`.
  - `F_DOWN`:
    - When `ks`=1, return to `UP`; the counter clears.
    - Otherwise the counter increments.
    - When the counter reaches `DEBOUNCE_CYC`-1 with `ks`=0, go to `DOWN`, set `key_state`=0 and pulse `key_flag`.
  - `F_UP`: mirror of `F_DOWN`. On acceptance, go to `UP` with `key_state`=1. No pulse is generated on release.
- **Classifier FSM:**
  - States: `C_IDLE`, `C_HELD`, `C_LONG`, `C_GAP`, `C_HELD2`. Hold/gap counter is `$clog2(max(LONG_CYC,DOUBLE_CYC))` bits wide and is cleared on every state change.
  - Press event = cycle in which `key_flag` is high. Release event = cycle in which `key_state` goes 0→1.
  - `C_IDLE`: a press event moves to `C_HELD`.
  - `C_HELD`: the counter increments each cycle.
    - Counter reaching `LONG_CYC`-1: pulse `long_flag` and go to `C_LONG`.
    - Release event: go to `C_GAP`.
  - `C_LONG`: a release event returns to `C_IDLE` with no flag.
  - `C_GAP`: the counter increments each cycle.
    - Press event: pulse `double_flag` and go to `C_HELD2`.
    - Counter reaching `DOUBLE_CYC`-1: pulse `short_flag` and go to `C_IDLE`.
  - `C_HELD2`: a release event returns to `C_IDLE`. There is no long detection on the second press.
  - A press on the same cycle as the `C_GAP` timeout counts as a press: `double_flag` wins and `short_flag` is suppressed.
  - A third press after a double starts a new gesture from `C_IDLE`.
- **Outputs:** all outputs are registered. At most one of `short_flag`, `double_flag`, `long_flag` is high in any cycle.
- **Reset values:** `key_state`=1. `key_flag`, `short_flag`, `double_flag`, `long_flag` = 0. Both FSMs are idle and all counters are 0.
- **Reset mid-operation:** asserting `rst_n` clears everything immediately. A button still held after reset release must pass the full debounce again and then produces a fresh `key_flag`.

## Timing
- **`key_flag` latency:** `key_in` low and held from clk edge N gives `key_flag` high in the cycle after edge N+`DEBOUNCE_CYC`+2. `key_state` falls in that same cycle.
- **Release latency:** `key_state` rises `DEBOUNCE_CYC`+2 cycles after the last `key_in` rising edge.
- **Glitch rejection:** a glitch of `DEBOUNCE_CYC`-1 cycles or fewer never changes `key_state`.
- **`long_flag`:** pulses exactly `LONG_CYC` cycles after `key_flag`.
- **`short_flag`:** pulses exactly `DOUBLE_CYC` cycles after the release event.
- **`double_flag`:** coincides with the second `key_flag`.
- **Pulse width:** every flag is exactly one cycle wide.

## Test plan
Bench parameters: `DEBOUNCE_CYC`=8, `LONG_CYC`=100, `DOUBLE_CYC`=40.
- **Bounce rejection:** `key_in` low for 7 cycles, then high, repeated 5 times → `key_state` stays 1; no flags.
- **Clean short press:** `key_in` low at edge 10 for 30 cycles → `key_flag` one cycle after edge 20; release; `short_flag` exactly 40 cycles after `key_state` rises; `long_flag`=0.
- **Double press:** two 20-cycle presses with a 15-cycle gap → `key_flag` twice; `double_flag` on the second `key_flag` cycle; `short_flag` never asserts.
- **Long press:** `key_in` low for 150 cycles → `key_flag` once; `long_flag` exactly 100 cycles later; release produces no flag.
- **Gap boundary:** second press accepted on the same cycle the gap counter reaches 39 → `double_flag`=1, `short_flag`=0.
- **Reset mid-hold:** `rst_n` low at hold count 50 while `key_in` stays low → all outputs reset; after release of `rst_n`, `key_flag` again after 8+2 cycles; `long_flag` 100 cycles after that.
